// File: rtl/codificador_linhas_registrado_pkg.sv
// Shared constants and helpers for the registered line encoder.
package codificador_linhas_registrado_pkg;

   localparam int MODE_ONE_HOT  = 0;
   localparam int MODE_PRIORITY = 1;

   // Code 0 is reserved to mean "no line / no event".
   localparam int CODE_NONE = 0;

   // Ceiling log2 usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/codificador_linhas_registrado_fila.sv
// Synchronous first-word-fall-through event FIFO. The head word is visible on
// data_o whenever the FIFO is non-empty; data_o reads 0 when empty. A push
// while full is accepted only if a pop happens in the same cycle.
module fila_eventos
   import codificador_linhas_registrado_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign level_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) begin
         wr_d = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + LVL_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - LVL_W'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: data_o is forced to 0 while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/codificador_linhas_registrado.sv
// Registered line encoder: synchronises and debounces raw lines, encodes each
// newly accepted pattern into a line code and queues it as one event.
module codificador_linhas_registrado
   import codificador_linhas_registrado_pkg::*;
#(
   parameter int N_LINES  = 7,
   parameter int CODE_W   = $clog2(N_LINES + 1),
   parameter int DEBOUNCE = 4,
   parameter int DEPTH    = 4,
   parameter int MODE     = MODE_ONE_HOT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_LINES-1:0]         lines_i,
   input  logic                       enable_i,
   input  logic                       clear_i,
   output logic [CODE_W-1:0]          code_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   output logic                       invalid_o
);

   localparam int               CNT_W    = clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic [N_LINES-1:0] sync1_q, sync2_q;
   logic [N_LINES-1:0] cand_q, cand_d;
   logic [N_LINES-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               overflow_q, overflow_d;
   logic               invalid_q, invalid_d;

   logic               accept;
   logic               multi_hot;
   logic [CODE_W-1:0]  highest;
   logic [CODE_W-1:0]  enc_code;
   logic               push_req;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;

   // Two-flop synchroniser on every raw line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= lines_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a new candidate restarts the count, which saturates at DEBOUNCE-1.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CNT_LAST) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // A pattern is accepted once, when it has settled and differs from the last accepted one.
   assign accept   = (sync2_q == cand_q) && (cnt_q == CNT_LAST) && (cand_q != stable_q);
   assign stable_d = accept ? cand_q : stable_q;

   // Encode the candidate: highest set line wins; multi-hot is rejected in one-hot mode.
   always_comb begin
      highest = CODE_W'(CODE_NONE);
      for (int i = 0; i < N_LINES; i++) begin
         if (cand_q[i]) begin
            highest = CODE_W'(i + 1);
         end
      end
      multi_hot = |(cand_q & (cand_q - N_LINES'(1)));
      enc_code  = CODE_W'(CODE_NONE);
      if (cand_q != '0) begin
         if (!multi_hot || (MODE == MODE_PRIORITY)) begin
            enc_code = highest;
         end
      end
   end

   assign push_req  = accept && enable_i && (enc_code != CODE_W'(CODE_NONE));
   assign pop       = valid_o && ready_i;
   assign invalid_d = accept && multi_hot && (MODE == MODE_ONE_HOT);

   // A new drop wins over a simultaneous clear so no overflow is ever lost.
   assign overflow_d = (push_req && fifo_full && !pop) || (overflow_q && !clear_i);

   // Debounce, acceptance and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q     <= '0;
         cnt_q      <= '0;
         stable_q   <= '0;
         overflow_q <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         overflow_q <= overflow_d;
         invalid_q  <= invalid_d;
      end
   end

   fila_eventos #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fila (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_req),
      .data_i  (enc_code),
      .pop_i   (pop),
      .data_o  (code_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   assign valid_o    = !fifo_empty;
   assign overflow_o = overflow_q;
   assign invalid_o  = invalid_q;

endmodule

// File: tb/tb_codificador_linhas_registrado.sv
module tb_codificador_linhas_registrado;

   localparam int N   = 7;
   localparam int D   = 4;
   localparam int DEP = 4;

   logic            clk;
   logic            reset;
   logic [N-1:0]    lines;
   logic            enable;
   logic            clear;
   logic            ready;

   // index 0: ONE_HOT instance, index 1: PRIORITY instance
   logic [1:0][2:0] code_w;
   logic [1:0]      valid_w;
   logic [1:0][2:0] level_w;
   logic [1:0]      ovf_w;
   logic [1:0]      inv_w;

   int checks   = 0;
   int failures = 0;
   bit started  = 0;

   codificador_linhas_registrado #(
      .N_LINES(N), .DEBOUNCE(D), .DEPTH(DEP), .MODE(0)
   ) dut_oh (
      .clk(clk), .reset(reset), .lines_i(lines), .enable_i(enable), .clear_i(clear),
      .code_o(code_w[0]), .valid_o(valid_w[0]), .ready_i(ready), .level_o(level_w[0]),
      .overflow_o(ovf_w[0]), .invalid_o(inv_w[0])
   );

   codificador_linhas_registrado #(
      .N_LINES(N), .DEBOUNCE(D), .DEPTH(DEP), .MODE(1)
   ) dut_pr (
      .clk(clk), .reset(reset), .lines_i(lines), .enable_i(enable), .clear_i(clear),
      .code_o(code_w[1]), .valid_o(valid_w[1]), .ready_i(ready), .level_o(level_w[1]),
      .overflow_o(ovf_w[1]), .invalid_o(inv_w[1])
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   // hist[j] holds the line value sampled at edge (e-1-j). A pattern P is
   // accepted at edge e when the samples at edges e-D-2 .. e-2 all equal P
   // and P differs from the last accepted pattern.
   logic [N-1:0] hist [D+2];
   logic [N-1:0] stable_m [2];
   int           fifo_m [2][DEP];
   int           cnt_m [2];
   bit           ovf_m [2];
   bit           inv_m [2];
   logic [N-1:0] p;
   bit           acc, acc_m, popped;
   int           ones, hi, code_m;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int j = 0; j < D + 2; j++) hist[j] = '0;
            for (int m = 0; m < 2; m++) begin
               stable_m[m] = '0;
               cnt_m[m]    = 0;
               ovf_m[m]    = 0;
               inv_m[m]    = 0;
            end
            started = 1;
         end else if (started) begin
            p   = hist[1];
            acc = 1;
            for (int j = 1; j < D + 2; j++) if (hist[j] != p) acc = 0;
            ones = $countones(p);
            hi   = 0;
            for (int i = 0; i < N; i++) if (p[i]) hi = i + 1;
            for (int m = 0; m < 2; m++) begin
               acc_m  = acc && (p != stable_m[m]);
               code_m = 0;
               if (ones == 1 || (ones > 1 && m == 1)) code_m = hi;
               inv_m[m] = acc_m && (ones > 1) && (m == 0);
               popped = (cnt_m[m] > 0) && ready;
               if (popped) begin
                  for (int j = 0; j < DEP - 1; j++) fifo_m[m][j] = fifo_m[m][j+1];
                  cnt_m[m]--;
               end
               if (acc_m && enable && code_m != 0 && cnt_m[m] == DEP) ovf_m[m] = 1;
               else if (clear) ovf_m[m] = 0;
               if (acc_m && enable && code_m != 0 && cnt_m[m] < DEP) begin
                  fifo_m[m][cnt_m[m]] = code_m;
                  cnt_m[m]++;
               end
               if (acc_m) stable_m[m] = p;
            end
            for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = lines;
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int m = 0; m < 2; m++) begin
               check($sformatf("model_valid[%0d]", m), 32'(valid_w[m]), 32'(cnt_m[m] > 0));
               check($sformatf("model_code[%0d]", m), 32'(code_w[m]),
                     (cnt_m[m] > 0) ? fifo_m[m][0] : 0);
               check($sformatf("model_level[%0d]", m), 32'(level_w[m]), cnt_m[m]);
               check($sformatf("model_overflow[%0d]", m), 32'(ovf_w[m]), 32'(ovf_m[m]));
               check($sformatf("model_invalid[%0d]", m), 32'(inv_w[m]), 32'(inv_m[m]));
            end
         end
      end
   end

   task automatic press_release(input logic [N-1:0] pat);
      lines = pat;
      step(8);
      lines = '0;
      step(8);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [N-1:0] seq [5];
      seq[0] = 7'h01; seq[1] = 7'h02; seq[2] = 7'h04; seq[3] = 7'h08; seq[4] = 7'h10;

      reset = 1; lines = 7'h7F; enable = 1; clear = 0; ready = 1;

      // 1: reset with all lines high, then re-acceptance of the held pattern
      step(3);
      for (int m = 0; m < 2; m++) begin
         check("rst_code", 32'(code_w[m]), 0);
         check("rst_valid", 32'(valid_w[m]), 0);
         check("rst_level", 32'(level_w[m]), 0);
         check("rst_overflow", 32'(ovf_w[m]), 0);
         check("rst_invalid", 32'(inv_w[m]), 0);
      end
      reset = 0;
      step(6);
      check("t1_pr_early_valid", 32'(valid_w[1]), 0);
      step(1);
      check("t1_pr_valid", 32'(valid_w[1]), 1);
      check("t1_pr_code", 32'(code_w[1]), 7);
      check("t1_oh_valid", 32'(valid_w[0]), 0);
      check("t1_oh_invalid", 32'(inv_w[0]), 1);
      step(1);
      check("t1_pr_popped", 32'(valid_w[1]), 0);
      check("t1_oh_invalid_pulse", 32'(inv_w[0]), 0);
      lines = '0;
      step(10);

      // 2: single line latency and release without event
      lines = 7'b0000100;
      step(6);
      check("t2_early_valid", 32'(valid_w[0]), 0);
      step(1);
      for (int m = 0; m < 2; m++) begin
         check("t2_valid", 32'(valid_w[m]), 1);
         check("t2_code", 32'(code_w[m]), 3);
      end
      step(1);
      check("t2_valid_drop", 32'(valid_w[0]), 0);
      lines = '0;
      step(10);
      check("t2_release_valid", 32'(valid_w[1]), 0);

      // 3: bouncing line never settles
      repeat (3) begin
         lines = 7'h40; step(2);
         lines = 7'h00; step(2);
      end
      for (int c = 0; c < 10; c++) begin
         check("t3_bounce_valid", 32'(valid_w[1]), 0);
         step(1);
      end
      check("t3_bounce_level", 32'(level_w[0]), 0);

      // nonzero -> nonzero change, and disabled acceptance
      lines = 7'h01; step(10);
      lines = 7'h03; step(10);
      enable = 0; lines = 7'h08; step(10);
      enable = 1; step(5);
      check("en_hold_valid", 32'(valid_w[1]), 0);
      lines = '0; step(10);

      // 4: overflow with consumer stalled, then ordered drain and clear
      ready = 0;
      for (int i = 0; i < 5; i++) press_release(seq[i]);
      for (int m = 0; m < 2; m++) begin
         check("t4_level_full", 32'(level_w[m]), 4);
         check("t4_overflow", 32'(ovf_w[m]), 1);
      end
      ready = 1;
      for (int i = 1; i <= 4; i++) begin
         check("t4_drain_code", 32'(code_w[1]), i);
         check("t4_drain_valid", 32'(valid_w[1]), 1);
         step(1);
      end
      check("t4_drained", 32'(valid_w[1]), 0);
      clear = 1; step(1); clear = 0;
      check("t4_clear_oh", 32'(ovf_w[0]), 0);
      check("t4_clear_pr", 32'(ovf_w[1]), 0);

      // 5: push and pop together while full
      ready = 0;
      for (int i = 0; i < 4; i++) press_release(seq[i]);
      check("t5_full", 32'(level_w[1]), 4);
      lines = 7'h20;
      step(6);
      ready = 1;
      step(1);
      check("t5_level_kept", 32'(level_w[1]), 4);
      check("t5_no_overflow", 32'(ovf_w[1]), 0);
      check("t5_head", 32'(code_w[1]), 2);
      step(6);
      lines = '0;
      step(10);
      check("t5_empty", 32'(level_w[0]), 0);

      // 6: reset in the middle of a debounce with a partly full FIFO
      ready = 0;
      for (int i = 0; i < 3; i++) press_release(seq[i]);
      check("t6_level3", 32'(level_w[1]), 3);
      lines = 7'h10;
      step(4);
      reset = 1;
      step(1);
      for (int m = 0; m < 2; m++) begin
         check("t6_rst_level", 32'(level_w[m]), 0);
         check("t6_rst_valid", 32'(valid_w[m]), 0);
      end
      reset = 0;
      step(6);
      check("t6_no_partial", 32'(valid_w[0]), 0);
      step(1);
      for (int m = 0; m < 2; m++) begin
         check("t6_reaccept_valid", 32'(valid_w[m]), 1);
         check("t6_reaccept_code", 32'(code_w[m]), 5);
      end
      ready = 1;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
